// File: rtl/ram16k_arb_pkg.sv
// Shared types and default sizes for the RAM16K arbiter slice.
package ram16k_arb_pkg;

  localparam int unsigned ADDR_W_DFLT = 14;
  localparam int unsigned DATA_W_DFLT = 16;
  localparam int unsigned DEPTH       = 16384;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; when both request, the side not granted last wins.
module rr_arbiter2 (
  input  logic       req_a,
  input  logic       req_b,
  input  logic       last_b,
  output logic [1:0] gnt_c
);

  always_comb begin
    gnt_c    = 2'b00;
    gnt_c[0] = req_a & (~req_b | last_b);
    gnt_c[1] = req_b & (~req_a | ~last_b);
  end

endmodule

// File: rtl/ram16k_arbiter.sv
// Two-port front end and clear sequencer for an external RAM16K (combinational read).
module ram16k_arbiter
  import ram16k_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W    = ADDR_W_DFLT,
  parameter int unsigned       DATA_W    = DATA_W_DFLT,
  parameter logic [DATA_W-1:0] CLR_VALUE = DATA_W'(16'h0000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr_done_d;
  logic              last_b_q;
  logic              run_en;
  logic [1:0]        pick_c;

  // State, clear counter and completion pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      clr_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clr_done <= clr_done_d;
    end
  end

  // Clear leaves from the last address straight to RUN, so the counter never wraps
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_d = 1'b0;
    case (state_q)
      RUN: begin
        cnt_d = '0;
        if (clr_start) state_d = CLEAR;
      end
      CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d    = RUN;
          cnt_d      = '0;
          clr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign clr_busy = (state_q == CLEAR);
  assign run_en   = (state_q == RUN) && !reset;

  rr_arbiter2 u_rr (
    .req_a  (a_req),
    .req_b  (b_req),
    .last_b (last_b_q),
    .gnt_c  (pick_c)
  );

  assign a_gnt = run_en & pick_c[0];
  assign b_gnt = run_en & pick_c[1];

  // RAM pin mux: clear sequencer, then granted requester, else idle
  always_comb begin
    ram_load    = 1'b0;
    ram_address = '0;
    ram_in      = '0;
    if (clr_busy) begin
      ram_load    = !reset;
      ram_address = cnt_q;
      ram_in      = CLR_VALUE;
    end else if (a_gnt) begin
      ram_load    = a_we;
      ram_address = a_addr;
      ram_in      = a_wdata;
    end else if (b_gnt) begin
      ram_load    = b_we;
      ram_address = b_addr;
      ram_in      = b_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_b_q <= 1'b1;
    end else if (a_gnt) begin
      last_b_q <= 1'b0;
    end else if (b_gnt) begin
      last_b_q <= 1'b1;
    end
  end

  // Read capture; rdata holds until that requester's next read
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
      if (a_gnt && !a_we) a_rdata <= ram_out;
      if (b_gnt && !b_we) b_rdata <= ram_out;
    end
  end

endmodule

// File: doc/ram16k_arbiter.md
RAM16K_ARBITER -- requirements
Module: ram16k_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; reset is sampled only on the rising edge of clk.
REQ-002 Parameter ADDR_W, default 14, SHALL set the RAM address width.
REQ-003 Parameter DATA_W, default 16, SHALL set the RAM word width.
REQ-004 Parameter CLR_VALUE, default 16'h0000, SHALL set the word written by the clear sequencer.
REQ-005 Port clk, input, 1 bit, SHALL be the rising-edge clock.
REQ-006 Port reset, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-007 Ports a_req and b_req, input, 1 bit each, SHALL be the per-requester access requests.
REQ-008 Ports a_we and b_we, input, 1 bit each, SHALL select write (1) or read (0).
REQ-009 Ports a_addr and b_addr, input, ADDR_W bits each, SHALL carry the access address.
REQ-010 Ports a_wdata and b_wdata, input, DATA_W bits each, SHALL carry the write data.
REQ-011 Ports a_gnt and b_gnt, output, 1 bit each, SHALL signal that the access is accepted in the current cycle.
REQ-012 Ports a_rvalid and b_rvalid, output, 1 bit each, SHALL signal that read data is valid.
REQ-013 Ports a_rdata and b_rdata, output, DATA_W bits each, SHALL carry the read data.
REQ-014 Port clr_start, input, 1 bit, SHALL request a full-memory clear.
REQ-015 Port clr_busy, output, 1 bit, SHALL be high while a clear is in progress.
REQ-016 Port clr_done, output, 1 bit, SHALL be a one-cycle pulse marking clear completion.
REQ-017 Ports ram_load (1 bit), ram_address (ADDR_W bits) and ram_in (DATA_W bits), output, SHALL drive the RAM16K load, address and in pins.
REQ-018 Port ram_out, input, DATA_W bits, SHALL receive the RAM16K out pin.

Function
REQ-019 The FSM SHALL have exactly two states: RUN and CLEAR.
REQ-020 In RUN, grants SHALL be combinational and issued in the same cycle as the request.
REQ-021 In RUN with a single requester active, that requester SHALL be granted.
REQ-022 In RUN with both requesters active, the grant SHALL go to the requester not granted most recently; the last-grant register SHALL reset to B so that A wins first.
REQ-023 At most one grant SHALL be asserted per cycle.
REQ-024 A requester SHALL hold req, we, addr and wdata stable until it is granted; the block SHALL NOT queue requests.
REQ-025 On a granted cycle, ram_address and ram_in SHALL carry the granted requester's addr and wdata, and ram_load SHALL equal its we.
REQ-026 On a granted read, ram_out SHALL be captured at the clock edge into that requester's rdata, and its rvalid SHALL be high for exactly the next cycle (1-cycle read latency).
REQ-027 rdata SHALL hold its value until the next read by the same requester.
REQ-028 A granted write SHALL NOT raise rvalid.
REQ-029 With no grant and no clear in progress, ram_load SHALL be 0 and ram_address SHALL be 0.
REQ-030 clr_start sampled high in RUN SHALL move the FSM to CLEAR at the next edge; any request in that same cycle SHALL still be granted.
REQ-031 In CLEAR, the block SHALL write CLR_VALUE to address counter values 0, 1, ..., 2^ADDR_W-1, one per cycle (16384 cycles at the default width), with ram_load=1.
REQ-032 In CLEAR, no grant SHALL be issued and clr_start SHALL be ignored.
REQ-033 clr_busy SHALL equal (state == CLEAR).
REQ-034 After the write to the last address, the FSM SHALL return to RUN without counter wrap-around.
REQ-035 clr_done SHALL pulse high for the first RUN cycle after a clear, and grants SHALL be allowed in that cycle.

Reset
REQ-036 On reset, the FSM SHALL enter RUN, the clear counter SHALL be 0, and last-grant SHALL be B.
REQ-037 On reset, a_rvalid, b_rvalid, a_rdata, b_rdata, clr_busy and clr_done SHALL be 0.
REQ-038 While reset is high, all grants and ram_load SHALL be forced to 0.
REQ-039 A reset asserted during CLEAR SHALL abort the clear without a clr_done pulse; RAM contents SHALL NOT be altered by reset.

Structure
REQ-040 A shared package ram16k_arb_pkg SHALL hold the state enum (RUN, CLEAR), ADDR_W/DATA_W defaults, and DEPTH = 16384.
REQ-041 A sub-module rr_arbiter2 SHALL implement the two-way round-robin pick (inputs: two requests, last-grant state; outputs: one-hot grant).
REQ-042 The RAM16K instance SHALL live in the parent design, not inside this block.

Verification
REQ-043 After reset, A writes 0xBEEF to 0x0005, then reads 0x0005 -> a_gnt is high in each request cycle, and a_rvalid=1 with a_rdata=0xBEEF in the cycle after the read grant.
REQ-044 A and B both request continuously for 4 cycles -> grant sequence is A, B, A, B.
REQ-045 Write 0x1234 to 0x3FFF, pulse clr_start -> clr_busy is high for exactly 16384 cycles, clr_done pulses once, and a read of 0x3FFF returns 0x0000.
REQ-046 B requests throughout a clear -> no b_gnt until the clr_done cycle; b_gnt is asserted in the clr_done cycle.
REQ-047 clr_start and a_req (write) in the same cycle -> a_gnt that cycle, clr_busy high from the next cycle, and the written address reads CLR_VALUE after the clear.
REQ-048 Reset asserted when the clear counter is 100 -> clr_busy is 0 the next cycle, no clr_done, and address 200 retains its pre-clear data.
